keypad_digit_capture: RTL and testbench
=======================================

Name: keypad_digit_capture

Overview:
- Upstream stage of the 8-digit scan display.
- Replaces the level-to-pulse and decimal-encoder front end.
- Samples the ten raw decimal key lines, synchronises and debounces them, and rejects multi-key presses.
- Emits exactly one single-cycle strobe and a 4-bit BCD code per accepted press; the digit shift register consumes these as its shift clock-enable and data.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press or a release (>=1).
- REPEAT_DELAY, 256: cycles of hold before the first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 64: cycles between later auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- key_in  input  10  raw key levels; bit i high = key "i" pressed; asynchronous to CLK.
- digit_valid  output  1  one-cycle strobe: new digit accepted.
- digit_code  output  4  BCD 0-9 of the last accepted digit; stable between strobes.
- multi_key  output  1  one-cycle strobe: a debounced pattern had more than one key.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: RST low forces the following immediately, regardless of CLK: digit_valid=0, multi_key=0, digit_code=0, busy=0, FSM=IDLE, counters=0, synchroniser flops=0.
- Synchroniser: key_in passes through a 2-flop synchroniser to give ks; the FSM sees only ks.
- Debounce counter: cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide and saturates; it never wraps.
- IDLE:
  - ks != 0: latch cand <= ks, cnt <= 0, go DEBOUNCE.
  - ks == 0: stay in IDLE.
- DEBOUNCE:
  - ks != cand: go IDLE with no output. Bounce or a pattern change restarts acquisition.
  - ks == cand and cnt == DEBOUNCE_CYCLES-1:
    - cand one-hot: pulse digit_valid for one cycle and load digit_code = index of the set bit (both registered in the same cycle).
    - otherwise: pulse multi_key for one cycle; digit_code is unchanged.
    - Either way, go HELD.
  - Otherwise: cnt++.
- HELD:
  - ks == 0: cnt <= 0, go RELEASE.
  - Other values, including extra keys pressed during the hold, are ignored and produce no output.
- RELEASE:
  - ks != 0: go back to HELD. Release bounce is never re-accepted as a new press.
  - ks == 0 for DEBOUNCE_CYCLES consecutive cycles: go IDLE.
- Latency: key_in stable from edge E1 (the first CLK edge that samples it) gives digit_valid high for the cycle after edge E(DEBOUNCE_CYCLES+3).
- Output exclusivity: digit_valid and multi_key are never high together. At most one strobe per press/release cycle, without KEY_REPEAT_EN.
- Asynchronous reset mid-operation: aborts any press; no strobe is issued. After reset release, a still-held key is treated as a new press.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - HELD with a one-hot cand additionally runs repeat counter rc.
  - The first repeat strobe (digit_valid, same digit_code) occurs REPEAT_DELAY cycles after the original strobe.
  - Further strobes follow every REPEAT_PERIOD cycles while ks == cand.
  - If ks differs from cand but is non-zero: repeat stops, and the FSM stays in HELD.
  - Entering RELEASE clears rc.
  - A multi_key press never repeats.
- Undefined: no repeat logic is synthesised; REPEAT_* parameters are unused.

Decomposition:
- Shared package keypad_pkg:
  - FSM state typedef: IDLE, DEBOUNCE, HELD, RELEASE.
  - NUM_KEYS=10, CODE_W=4.
  - Function onehot10_to_bcd.
  - Function is_onehot.
- One sub-module, key_sync: a parameterised-width 2-flop synchroniser with async active-low reset, instantiated with width 10.

Test Plan (DEBOUNCE_CYCLES=4):
- key_in=10'b0000001000 held for 20 cycles, then 0 -> one digit_valid exactly 7 cycles after the first sampling edge, digit_code=3, multi_key never set, busy back to 0 after release debounce.
- key_in bit 7 toggling every 2 cycles for 12 cycles, then stable for 10 cycles -> no strobe during toggling; a single digit_valid with code 7 once stable.
- key_in=10'b0000100001 stable -> one multi_key pulse; digit_code keeps its previous value; digit_valid stays 0.
- Press 5, then add key 9 while HELD, then release both with a 1-cycle bounce on release -> exactly one strobe with code 5; no strobe for 9 or for the bounce.
- RST driven low for 1 cycle during DEBOUNCE of key 2 -> all outputs 0 immediately; a held key produces digit_valid with code 2 starting 7 edges after RST rises.
- KEY_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8, key 0 held for 60 cycles -> strobes at t0, t0+20, t0+28, t0+36, t0+44, t0+52, all with code 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and one-hot helpers for keypad_digit_capture
package keypad_pkg;

  localparam int NUM_KEYS = 10;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_e;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  // Highest set bit wins; callers only pass one-hot vectors.
  function automatic logic [CODE_W-1:0] onehot10_to_bcd(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - parameterised-width 2-flop synchroniser, async active-low reset
module key_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// rtl/keypad_digit_capture.sv - debounced single-key capture to BCD strobe
// Optional auto-repeat while a digit is held: define KEY_REPEAT_EN.
module keypad_digit_capture
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                digit_valid,
  output logic [CODE_W-1:0]   digit_code,
  output logic                multi_key,
  output logic                busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] cand;
  logic [CW-1:0]       cnt;
  key_state_e          state;

  key_sync #(.WIDTH(NUM_KEYS)) u_key_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (key_in),
    .q     (ks)
  );

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam logic [RC_W-1:0] RC_FIRST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_NEXT  = RC_W'(REPEAT_PERIOD - 1);

  logic [RC_W-1:0] rc;
  logic            rep_on;
  logic            rep_first;
  logic [RC_W-1:0] rc_limit;

  assign rc_limit = rep_first ? RC_FIRST : RC_NEXT;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      digit_valid <= 1'b0;
      multi_key   <= 1'b0;
      digit_code  <= '0;
      busy        <= 1'b0;
`ifdef KEY_REPEAT_EN
      rc          <= '0;
      rep_on      <= 1'b0;
      rep_first   <= 1'b0;
`endif
    end else begin
      digit_valid <= 1'b0;
      multi_key   <= 1'b0;
      case (state)
        IDLE: begin
          if (ks != '0) begin
            cand  <= ks;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end

        DEBOUNCE: begin
          if (ks != cand) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            if (is_onehot(cand)) begin
              digit_valid <= 1'b1;
              digit_code  <= onehot10_to_bcd(cand);
            end else begin
              multi_key <= 1'b1;
            end
            state <= HELD;
`ifdef KEY_REPEAT_EN
            rc        <= '0;
            rep_on    <= is_onehot(cand);
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end

        // Extra keys during a hold never produce a new code.
        HELD: begin
          if (ks == '0) begin
            cnt   <= '0;
            state <= RELEASE;
`ifdef KEY_REPEAT_EN
            rc    <= '0;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (rep_on) begin
            if (ks != cand) begin
              rep_on <= 1'b0;
            end else if (rc == rc_limit) begin
              digit_valid <= 1'b1;
              rc          <= '0;
              rep_first   <= 1'b0;
            end else begin
              rc <= rc + RC_W'(1);
            end
          end
`endif
        end

        RELEASE: begin
          if (ks != '0) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_digit_capture.sv
// tb/tb_keypad_digit_capture.sv - self-checking bench for keypad_digit_capture
// Repeat checks are compiled in when KEY_REPEAT_EN is defined.
module tb_keypad_digit_capture;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       CLK;
  logic       RST;
  logic [9:0] key_in;
  logic       digit_valid;
  logic [3:0] digit_code;
  logic       multi_key;
  logic       busy;

  keypad_digit_capture #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .key_in      (key_in),
    .digit_valid (digit_valid),
    .digit_code  (digit_code),
    .multi_key   (multi_key),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int mk_cnt = 0;
  int edge_no = 0;

  // Reference model: run lengths of the synchronised key pattern.
  logic [9:0] p1, p2, m_cand;
  bit   m_acq, m_pressed, exp_dv, exp_mk, m_busy;
  int   m_stable, m_zero_run;
  logic [3:0] m_code;
`ifdef KEY_REPEAT_EN
  bit m_rep;
  int m_since, m_limit;
`endif

  function automatic int key_index(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    p1 = '0; p2 = '0; m_cand = '0;
    m_acq = 0; m_pressed = 0; exp_dv = 0; exp_mk = 0; m_busy = 0;
    m_stable = 0; m_zero_run = 0; m_code = '0;
`ifdef KEY_REPEAT_EN
    m_rep = 0; m_since = 0; m_limit = RD;
`endif
  endtask

  task automatic model_edge();
    logic [9:0] s;
`ifdef KEY_REPEAT_EN
    bit was_held;
`endif
    s = p2; p2 = p1; p1 = key_in;
    exp_dv = 0; exp_mk = 0;
    if (!m_pressed) begin
      if (m_acq) begin
        if (s != m_cand) m_acq = 0;
        else begin
          m_stable++;
          if (m_stable == D) begin
            m_acq = 0; m_pressed = 1; m_zero_run = 0;
            if ($countones(m_cand) == 1) begin
              exp_dv = 1; m_code = 4'(key_index(m_cand));
`ifdef KEY_REPEAT_EN
              m_rep = 1; m_since = 0; m_limit = RD;
`endif
            end else begin
              exp_mk = 1;
`ifdef KEY_REPEAT_EN
              m_rep = 0;
`endif
            end
          end
        end
      end else if (s != 0) begin
        m_acq = 1; m_cand = s; m_stable = 0;
      end
    end else if (s == 0) begin
`ifdef KEY_REPEAT_EN
      if (m_zero_run == 0) m_since = 0;
`endif
      m_zero_run++;
      if (m_zero_run == D + 1) m_pressed = 0;
    end else begin
`ifdef KEY_REPEAT_EN
      was_held = (m_zero_run == 0);
      if (was_held && m_rep) begin
        if (s != m_cand) m_rep = 0;
        else begin
          m_since++;
          if (m_since == m_limit) begin
            exp_dv = 1; m_since = 0; m_limit = RP;
          end
        end
      end
`endif
      m_zero_run = 0;
    end
    m_busy = m_acq || m_pressed;
  endtask

  task automatic step();
    @(posedge CLK);
    edge_no++;
    if (RST) model_edge();
    else model_reset();
    #1;
    if (digit_valid) dv_cnt++;
    if (multi_key) mk_cnt++;
    check("digit_valid", int'(digit_valid), int'(exp_dv));
    check("multi_key", int'(multi_key), int'(exp_mk));
    check("digit_code", int'(digit_code), int'(m_code));
    check("busy", int'(busy), int'(m_busy));
    check("strobe_excl", int'(digit_valid && multi_key), 0);
  endtask

  task automatic release_wait();
    int n;
    key_in = '0;
    repeat (3) step();
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("release_timeout", int'(busy), 0);
    repeat (2) step();
  endtask

  typedef struct {
    logic [9:0] key;
    int         hold;
    int         n_dv;
    int         n_mk;
    int         code;
  } vec_t;

  vec_t vecs[8];
  int first_dv;

  initial begin
    vecs[0] = '{10'h008, 20, 1, 0, 3};
    vecs[1] = '{10'h021, 15, 0, 1, 3};
    vecs[2] = '{10'h200, 12, 1, 0, 9};
    vecs[3] = '{10'h001, 10, 1, 0, 0};
    vecs[4] = '{10'h00c, 12, 0, 1, 0};
    vecs[5] = '{10'h010,  4, 0, 0, 0};
    vecs[6] = '{10'h040,  5, 1, 0, 6};
    vecs[7] = '{10'h3ff,  9, 0, 1, 6};

    RST = 1'b0;
    key_in = '0;
    model_reset();
    #3;
    check("rst_digit_valid", int'(digit_valid), 0);
    check("rst_multi_key", int'(multi_key), 0);
    check("rst_digit_code", int'(digit_code), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) step();
    RST = 1'b1;
    repeat (2) step();

    // Latency of a clean press of key 3.
    dv_cnt = 0; mk_cnt = 0; first_dv = 0;
    key_in = 10'h008;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (digit_valid && first_dv == 0) first_dv = i;
    end
    release_wait();
    check("latency_edges", first_dv, D + 3);
    check("latency_dv_count", dv_cnt, 1);
    check("latency_code", int'(digit_code), 3);
    check("latency_mk_count", mk_cnt, 0);

    for (int v = 0; v < 8; v++) begin
      dv_cnt = 0; mk_cnt = 0;
      key_in = vecs[v].key;
      repeat (vecs[v].hold) step();
      release_wait();
      check($sformatf("vec%0d_dv_count", v), dv_cnt, vecs[v].n_dv);
      check($sformatf("vec%0d_mk_count", v), mk_cnt, vecs[v].n_mk);
      check($sformatf("vec%0d_code", v), int'(digit_code), vecs[v].code);
    end

    // Key 7 bouncing, then stable.
    dv_cnt = 0; mk_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      key_in = ((i / 2) % 2 == 0) ? 10'h080 : 10'h000;
      step();
    end
    check("bounce_no_strobe", dv_cnt + mk_cnt, 0);
    key_in = 10'h080;
    repeat (10) step();
    release_wait();
    check("bounce_dv_count", dv_cnt, 1);
    check("bounce_code", int'(digit_code), 7);

    // Key 5, extra key 9 during hold, bounced release.
    dv_cnt = 0; mk_cnt = 0;
    key_in = 10'h020; repeat (10) step();
    key_in = 10'h220; repeat (6) step();
    key_in = 10'h000; step();
    key_in = 10'h220; step();
    release_wait();
    check("addkey_dv_count", dv_cnt, 1);
    check("addkey_mk_count", mk_cnt, 0);
    check("addkey_code", int'(digit_code), 5);

    // Reset during debounce of key 2.
    key_in = 10'h004;
    repeat (4) step();
    check("pre_reset_busy", int'(busy), 1);
    #2 RST = 1'b0;
    #1;
    model_reset();
    check("midrst_digit_valid", int'(digit_valid), 0);
    check("midrst_multi_key", int'(multi_key), 0);
    check("midrst_digit_code", int'(digit_code), 0);
    check("midrst_busy", int'(busy), 0);
    step();
    RST = 1'b1;
    dv_cnt = 0; first_dv = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (digit_valid && first_dv == 0) first_dv = i;
    end
    check("postrst_latency", first_dv, 7);
    check("postrst_code", int'(digit_code), 2);
    release_wait();

`ifdef KEY_REPEAT_EN
    begin
      int offs[$];
      int t0;
      int exp_offs[6] = '{0, 20, 28, 36, 44, 52};
      dv_cnt = 0;
      key_in = 10'h001;
      for (int i = 1; i <= 60; i++) begin
        step();
        if (digit_valid) begin
          offs.push_back(i);
          check("repeat_code", int'(digit_code), 0);
        end
      end
      release_wait();
      check("repeat_count", offs.size(), 6);
      t0 = (offs.size() > 0) ? offs[0] : 0;
      check("repeat_t0", t0, 7);
      for (int k = 0; k < 6; k++) begin
        if (k < offs.size()) check($sformatf("repeat_off%0d", k), offs[k] - t0, exp_offs[k]);
      end
    end
`endif

    // Randomised segments against the reference model.
    for (int seg = 0; seg < 250; seg++) begin
      int kind, len;
      logic [9:0] v;
      kind = $urandom_range(0, 9);
      v = '0;
      if (kind <= 5) v[$urandom_range(0, 9)] = 1'b1;
      else if (kind <= 7) begin
        v[$urandom_range(0, 9)] = 1'b1;
        v[$urandom_range(0, 9)] = 1'b1;
      end
`ifdef KEY_REPEAT_EN
      len = $urandom_range(1, 40);
`else
      len = $urandom_range(1, 12);
`endif
      key_in = v;
      repeat (len) step();
    end
    release_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
